tlul_sram_responder: RTL and testbench



---
 rtl/tlul_sram_responder.sv | 209 ++++++++++++++++++++
 tb/tb_tlul_sram_responder.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlul_sram_responder.sv
// TL-UL device-side responder for a single-cycle-latency SRAM macro.
// Requests are screened, issued to the SRAM in the accept cycle, staged for
// one cycle while read data comes back, then queued in an in-order response
// FIFO that drives channel D.

package tlul_pkg;
    localparam int TL_AIW = 8;
    localparam int TL_DUW = 14;

    localparam logic [2:0] PUT_FULL_DATA    = 3'd0;
    localparam logic [2:0] PUT_PARTIAL_DATA = 3'd1;
    localparam logic [2:0] GET              = 3'd4;
    localparam logic [2:0] ACCESS_ACK       = 3'd0;
    localparam logic [2:0] ACCESS_ACK_DATA  = 3'd1;

    localparam logic [TL_DUW-1:0] TL_D_USER_DEFAULT = '0;

    typedef struct packed {
        logic              a_valid;
        logic [2:0]        a_opcode;
        logic [2:0]        a_param;
        logic [1:0]        a_size;
        logic [TL_AIW-1:0] a_source;
        logic [31:0]       a_address;
        logic [3:0]        a_mask;
        logic [31:0]       a_data;
        logic              d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic              d_valid;
        logic [2:0]        d_opcode;
        logic [2:0]        d_param;
        logic [1:0]        d_size;
        logic [TL_AIW-1:0] d_source;
        logic              d_sink;
        logic [31:0]       d_data;
        logic [TL_DUW-1:0] d_user;
        logic              d_error;
        logic              a_ready;
    } tl_d2h_t;
endpackage

module tlul_sram_responder
    import tlul_pkg::*;
#(
    parameter int Depth    = 256,
    parameter int RspDepth = 4,
    localparam int AW      = $clog2(Depth)
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  tl_h2d_t        tl_i,
    output tl_d2h_t        tl_o,
    output logic           mem_req_o,
    output logic           mem_we_o,
    output logic [AW-1:0]  mem_addr_o,
    output logic [31:0]    mem_wdata_o,
    output logic [3:0]     mem_wmask_o,
    input  logic [31:0]    mem_rdata_i
);

    localparam int CW = $clog2(RspDepth + 1);
    localparam int PW = $clog2(RspDepth);

    typedef struct packed {
        logic              is_read;
        logic              error;
        logic [TL_AIW-1:0] source;
        logic [1:0]        size;
        logic [31:0]       data;
    } rsp_t;

    // Request screening and acceptance
    logic          a_ready;
    logic          accept;
    logic          req_err;
    logic          bad_op;
    logic          bad_size;
    logic          misaligned;
    logic          out_of_range;
    logic          bad_mask;
    logic [CW:0]   occ;

    // Stage register: one entry waiting for SRAM read data
    logic              stage_valid;
    logic              stage_is_read;
    logic              stage_error;
    logic [TL_AIW-1:0] stage_source;
    logic [1:0]        stage_size;

    // Response FIFO
    rsp_t          fifo_mem [RspDepth];
    rsp_t          push_entry;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;
    logic          d_valid;

    // Fields of the request that the responder has no use for
    logic unused_fields;
    assign unused_fields = ^tl_i.a_param;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(RspDepth - 1)) ? '0 : p + 1'b1;
    endfunction

    // The staged entry still owns a FIFO slot, so it is counted in occupancy;
    // this keeps a_ready purely registered.
    assign occ     = {1'b0, count} + (CW + 1)'(stage_valid);
    assign a_ready = occ < (CW + 1)'(RspDepth);
    assign accept  = tl_i.a_valid & a_ready;

    // Protocol and range screening of the incoming request
    always_comb begin
        bad_op       = !((tl_i.a_opcode == GET) ||
                         (tl_i.a_opcode == PUT_FULL_DATA) ||
                         (tl_i.a_opcode == PUT_PARTIAL_DATA));
        bad_size     = tl_i.a_size > 2'd2;
        misaligned   = |tl_i.a_address[1:0];
        out_of_range = tl_i.a_address >= 32'(Depth * 4);
        bad_mask     = (tl_i.a_opcode == PUT_FULL_DATA) && (tl_i.a_mask != 4'hf);
        req_err      = bad_op | bad_size | misaligned | out_of_range | bad_mask;
    end

    // SRAM strobe is gated by reset so it drops without waiting for a clock
    assign mem_req_o   = accept & ~req_err & ~rst_i;
    assign mem_we_o    = mem_req_o & (tl_i.a_opcode != GET);
    assign mem_addr_o  = tl_i.a_address[AW+1:2];
    assign mem_wdata_o = tl_i.a_data;
    assign mem_wmask_o = tl_i.a_mask;

    // Stage register captures the accepted request's response attributes
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stage_valid   <= 1'b0;
            stage_is_read <= 1'b0;
            stage_error   <= 1'b0;
            stage_source  <= '0;
            stage_size    <= '0;
        end else begin
            stage_valid <= accept;
            if (accept) begin
                stage_is_read <= (tl_i.a_opcode == GET);
                stage_error   <= req_err;
                stage_source  <= tl_i.a_source;
                stage_size    <= tl_i.a_size;
            end
        end
    end

    // Build the FIFO entry; SRAM read data is valid now, one cycle after the strobe
    always_comb begin
        push_entry         = '0;
        push_entry.is_read = stage_is_read;
        push_entry.error   = stage_error;
        push_entry.source  = stage_source;
        push_entry.size    = stage_size;
        if (stage_is_read) begin
            push_entry.data = stage_error ? 32'hFFFF_FFFF : mem_rdata_i;
        end
    end

    assign push    = stage_valid;
    assign d_valid = (count != '0);
    assign pop     = d_valid & tl_i.d_ready;

    // FIFO storage; contents are only observed through the valid-gated head
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr] <= push_entry;
        end
    end

    // FIFO pointers and occupancy count
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Channel D driven from the FIFO head; fields are zero while idle
    always_comb begin
        tl_o         = '0;
        tl_o.a_ready = a_ready;
        tl_o.d_user  = TL_D_USER_DEFAULT;
        if (d_valid) begin
            tl_o.d_valid  = 1'b1;
            tl_o.d_opcode = fifo_mem[rd_ptr].is_read ? ACCESS_ACK_DATA : ACCESS_ACK;
            tl_o.d_size   = fifo_mem[rd_ptr].size;
            tl_o.d_source = fifo_mem[rd_ptr].source;
            tl_o.d_data   = fifo_mem[rd_ptr].data;
            tl_o.d_error  = fifo_mem[rd_ptr].error;
        end
    end

endmodule

// File: tb/tb_tlul_sram_responder.sv
// Directed bench for tlul_sram_responder: single transactions, error
// screening, backpressure, streaming and mid-operation reset.
module tb_tlul_sram_responder;
    import tlul_pkg::*;

    localparam int Depth    = 256;
    localparam int RspDepth = 4;
    localparam int AW       = 8;

    // Clock and reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tl_h2d_t       tl_i;
    tl_d2h_t       tl_o;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_wmask;
    logic [31:0]   mem_rdata;

    tlul_sram_responder #(.Depth(Depth), .RspDepth(RspDepth)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .tl_i        (tl_i),
        .tl_o        (tl_o),
        .mem_req_o   (mem_req),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_wmask_o (mem_wmask),
        .mem_rdata_i (mem_rdata)
    );

    // SRAM model: byte-masked writes, read data one cycle after the strobe
    logic [31:0] mem_model [Depth];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < Depth; i++) mem_model[i] <= '0;
            mem_rdata <= '0;
        end else if (mem_req) begin
            if (mem_we) begin
                if (mem_wmask[0]) mem_model[mem_addr][7:0]   <= mem_wdata[7:0];
                if (mem_wmask[1]) mem_model[mem_addr][15:8]  <= mem_wdata[15:8];
                if (mem_wmask[2]) mem_model[mem_addr][23:16] <= mem_wdata[23:16];
                if (mem_wmask[3]) mem_model[mem_addr][31:24] <= mem_wdata[31:24];
            end else begin
                mem_rdata <= mem_model[mem_addr];
            end
        end
    end

    // Scoreboard state
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q[$];
    logic        mon_en  = 1'b0;

    // SRAM-side values captured in the accept cycle
    logic          cap_req;
    logic          cap_we;
    logic [AW-1:0] cap_addr;
    logic [31:0]   cap_wdata;
    logic [3:0]    cap_wmask;
    int            stalls;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present a request, wait (bounded) for a_ready, capture SRAM outputs,
    // and return at the next falling edge with a_valid dropped.
    task automatic issue(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] mask, input logic [7:0] src, output int n_stall);
        n_stall = 0;
        tl_i.a_valid   = 1'b1;
        tl_i.a_opcode  = op;
        tl_i.a_size    = 2'd2;
        tl_i.a_address = addr;
        tl_i.a_data    = data;
        tl_i.a_mask    = mask;
        tl_i.a_source  = src;
        #1;
        while (!tl_o.a_ready && n_stall < 20) begin
            @(negedge clk);
            #1;
            n_stall++;
        end
        if (!tl_o.a_ready) check("accept_timeout", 32'd0, 32'd1);
        cap_req   = mem_req;
        cap_we    = mem_we;
        cap_addr  = mem_addr;
        cap_wdata = mem_wdata;
        cap_wmask = mem_wmask;
        @(posedge clk);
        @(negedge clk);
        tl_i.a_valid = 1'b0;
    endtask

    // Wait (bounded) for a response at the D head, check it, let it pop
    task automatic expect_rsp(input string tag, input logic [2:0] op, input logic err,
                              input logic [31:0] data, input logic [7:0] src);
        int waited = 0;
        while (!tl_o.d_valid && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_valid"},  32'(tl_o.d_valid),  32'd1);
        check({tag, "_opcode"}, 32'(tl_o.d_opcode), 32'(op));
        check({tag, "_error"},  32'(tl_o.d_error),  32'(err));
        check({tag, "_data"},   tl_o.d_data,        data);
        check({tag, "_source"}, 32'(tl_o.d_source), 32'(src));
        check({tag, "_size"},   32'(tl_o.d_size),   32'd2);
        @(posedge clk);
        @(negedge clk);
    endtask

    // In-order response monitor for multi-request phases
    always @(negedge clk) begin
        #2;
        if (mon_en && tl_o.d_valid && tl_i.d_ready) begin
            if (exp_q.size() == 0) check("mon_extra_rsp", 32'd1, 32'd0);
            else                   check("mon_source", 32'(tl_o.d_source), exp_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        tl_i         = '0;
        tl_i.d_ready = 1'b1;
        rst          = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_a_ready", 32'(tl_o.a_ready), 32'd1);
        check("rst_d_valid", 32'(tl_o.d_valid), 32'd0);
        check("rst_d_data",  tl_o.d_data,       32'd0);
        check("rst_mem_req", 32'(mem_req),      32'd0);
        check("rst_mem_we",  32'(mem_we),       32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Full write then read back, including the two-cycle latency
        issue(PUT_FULL_DATA, 32'd100, 32'd100, 4'hf, 8'd1, stalls);
        check("wr_mem_req",  32'(cap_req),   32'd1);
        check("wr_mem_we",   32'(cap_we),    32'd1);
        check("wr_mem_addr", 32'(cap_addr),  32'd25);
        check("wr_wdata",    cap_wdata,      32'd100);
        check("wr_lat_n1",   32'(tl_o.d_valid), 32'd0);
        @(negedge clk);
        check("wr_lat_n2",   32'(tl_o.d_valid), 32'd1);
        expect_rsp("wr_ack", ACCESS_ACK, 1'b0, 32'd0, 8'd1);

        issue(GET, 32'd100, 32'd0, 4'hf, 8'd2, stalls);
        check("rd_mem_req",  32'(cap_req),  32'd1);
        check("rd_mem_we",   32'(cap_we),   32'd0);
        check("rd_mem_addr", 32'(cap_addr), 32'd25);
        expect_rsp("rd_data", ACCESS_ACK_DATA, 1'b0, 32'd100, 8'd2);

        // Partial write merges only the low two bytes into a zeroed word
        issue(PUT_PARTIAL_DATA, 32'd200, 32'hAABBCCDD, 4'b0011, 8'd3, stalls);
        check("pp_wmask",    32'(cap_wmask), 32'd3);
        check("pp_mem_we",   32'(cap_we),    32'd1);
        check("pp_mem_addr", 32'(cap_addr),  32'd50);
        expect_rsp("pp_ack", ACCESS_ACK, 1'b0, 32'd0, 8'd3);
        issue(GET, 32'd200, 32'd0, 4'hf, 8'd4, stalls);
        expect_rsp("pp_rd", ACCESS_ACK_DATA, 1'b0, 32'h0000CCDD, 8'd4);

        // Error screening: none of these may strobe the SRAM
        issue(3'd2, 32'd4, 32'h1234, 4'hf, 8'd5, stalls);
        check("err_op_req", 32'(cap_req), 32'd0);
        expect_rsp("err_op", ACCESS_ACK, 1'b1, 32'd0, 8'd5);
        issue(GET, 32'(Depth * 4), 32'd0, 4'hf, 8'd6, stalls);
        check("err_range_req", 32'(cap_req), 32'd0);
        expect_rsp("err_range", ACCESS_ACK_DATA, 1'b1, 32'hFFFF_FFFF, 8'd6);
        issue(GET, 32'd101, 32'd0, 4'hf, 8'd7, stalls);
        check("err_align_req", 32'(cap_req), 32'd0);
        expect_rsp("err_align", ACCESS_ACK_DATA, 1'b1, 32'hFFFF_FFFF, 8'd7);
        issue(PUT_FULL_DATA, 32'd8, 32'h55, 4'h7, 8'd8, stalls);
        check("err_mask_req", 32'(cap_req), 32'd0);
        expect_rsp("err_mask", ACCESS_ACK, 1'b1, 32'd0, 8'd8);

        // Highest legal word is accepted without error
        issue(GET, 32'(Depth * 4 - 4), 32'd0, 4'hf, 8'd9, stalls);
        check("top_req",  32'(cap_req),  32'd1);
        check("top_addr", 32'(cap_addr), 32'd255);
        expect_rsp("top_rd", ACCESS_ACK_DATA, 1'b0, 32'd0, 8'd9);

        // Backpressure: four accepted, then a_ready drops and D holds
        tl_i.d_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(32'(i));
            issue(GET, 32'd0, 32'd0, 4'hf, 8'(i), stalls);
            check("bp_accept_stall", 32'(stalls), 32'd0);
        end
        tl_i.a_valid  = 1'b1;
        tl_i.a_source = 8'd4;
        #1;
        check("bp_full_a_ready", 32'(tl_o.a_ready), 32'd0);
        check("bp_full_mem_req", 32'(mem_req),      32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("bp_hold_a_ready", 32'(tl_o.a_ready),  32'd0);
            check("bp_hold_valid",   32'(tl_o.d_valid),  32'd1);
            check("bp_hold_source",  32'(tl_o.d_source), 32'd0);
            check("bp_hold_mem_req", 32'(mem_req),       32'd0);
        end
        mon_en       = 1'b1;
        tl_i.d_ready = 1'b1;
        exp_q.push_back(32'd4);
        issue(GET, 32'd0, 32'd0, 4'hf, 8'd4, stalls);
        check("bp_ready_after_pop", 32'(stalls), 32'd1);
        exp_q.push_back(32'd5);
        issue(GET, 32'd0, 32'd0, 4'hf, 8'd5, stalls);
        check("bp_last_stall", 32'(stalls), 32'd0);
        for (int i = 0; i < 30 && exp_q.size() != 0; i++) @(negedge clk);
        check("bp_drained", 32'(exp_q.size()), 32'd0);

        // Streaming: one accept per cycle with d_ready held high
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(32'(16 + i));
            issue(PUT_FULL_DATA, 32'(4 * i), 32'(3 * i), 4'hf, 8'(16 + i), stalls);
            check("stream_stall", 32'(stalls), 32'd0);
        end
        for (int i = 0; i < 30 && exp_q.size() != 0; i++) @(negedge clk);
        check("stream_drained", 32'(exp_q.size()), 32'd0);
        mon_en = 1'b0;

        // Reset with two responses pending
        tl_i.d_ready = 1'b0;
        issue(GET, 32'd0, 32'd0, 4'hf, 8'd30, stalls);
        issue(GET, 32'd4, 32'd0, 4'hf, 8'd31, stalls);
        @(negedge clk);
        check("mr_pending_valid", 32'(tl_o.d_valid), 32'd1);
        tl_i.a_valid   = 1'b1;
        tl_i.a_opcode  = GET;
        tl_i.a_address = 32'd0;
        tl_i.a_mask    = 4'hf;
        #1;
        check("mr_pre_mem_req", 32'(mem_req), 32'd1);
        rst = 1'b1;
        #1;
        check("mr_mem_req", 32'(mem_req),      32'd0);
        check("mr_d_valid", 32'(tl_o.d_valid), 32'd0);
        check("mr_a_ready", 32'(tl_o.a_ready), 32'd1);
        @(negedge clk);
        tl_i.a_valid = 1'b0;
        tl_i.d_ready = 1'b1;
        rst          = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("mr_no_stale", 32'(tl_o.d_valid), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
